// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit framer.
// Accepts one word over a VALID/READY handshake into a PISO shift register,
// then sends start bit, SIZE data bits (MSB first), optional even parity and
// STOP_BITS stop bits on a registered, idle-high TX line.
//
// Handshake: a word transfers on a rising CLK edge where VALID=1 and READY=1.
// READY is high only in IDLE; VALID while READY=0 is ignored (no queueing) and
// DATA_IN is only sampled on the transfer edge.
module uart_tx_serializer #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SIZE-1:0] DATA_IN,
  input  logic            VALID,
  output logic            READY,
  output logic            TX,
  output logic            BUSY,
  output logic            DONE,
  output logic [2:0]      DBG_STATE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(SIZE + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic [2:0]      r_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [SIZE-1:0] r_shift;
  logic            r_parity;
  logic            r_tx;

  logic w_accept;
  logic w_tick;

  assign w_accept = VALID && (r_state == S_IDLE);
  assign w_tick   = (r_clk_cnt == CNT_LAST);

  // Frame sequencer: bit timing, shift register and registered TX line.
  // r_bit_cnt counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b1;
          if (w_accept) begin
            r_shift  <= DATA_IN;
            r_parity <= ^DATA_IN;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[SIZE-1];
            r_shift   <= r_shift << 1;
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[SIZE-1];
              r_shift   <= r_shift << 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

  // Status outputs decoded from registered state; DONE marks the last cycle
  // of the final stop bit.
  always_comb begin
    READY     = (r_state == S_IDLE);
    BUSY      = (r_state != S_IDLE);
    DONE      = (r_state == S_STOP) && w_tick && (r_bit_cnt == STOP_LAST);
    TX        = r_tx;
    DBG_STATE = r_state;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: two serializer instances (8N1 and 8E2, 4 clocks per
// bit) share one stimulus stream. A frame-level model expands each accepted
// word into its expected per-cycle TX waveform; outputs are sampled on the
// falling edge.
module tb_uart_tx_serializer;

  localparam int CPB  = 4;
  localparam int P0   = 0;
  localparam int S0   = 1;
  localparam int P1   = 1;
  localparam int S1   = 2;

  // clock / reset
  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DATA_IN;
  logic       VALID;
  logic [1:0] rdy_w, tx_w, busy_w, done_w;
  logic [2:0] st0_w, st1_w;

  always #5 CLK = ~CLK;

  uart_tx_serializer #(.SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(P0), .STOP_BITS(S0)) dut0 (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .VALID(VALID), .READY(rdy_w[0]),
    .TX(tx_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .DBG_STATE(st0_w));

  uart_tx_serializer #(.SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(P1), .STOP_BITS(S1)) dut1 (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .VALID(VALID), .READY(rdy_w[1]),
    .TX(tx_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .DBG_STATE(st1_w));

  // scoreboard
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  logic [1:0] m_ready;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_exp[2];
  int         done_seen[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected waveform of one frame: every bit repeated CPB cycles.
  task automatic push_frame(input int i, input logic [7:0] d);
    logic [0:0] bits[$];
    int par, stp;
    par = (i == 0) ? P0 : P1;
    stp = (i == 0) ? S0 : S1;
    bits.push_back(1'b0);
    for (int k = 7; k >= 0; k--) bits.push_back(d[k]);
    if (par != 0) bits.push_back(($countones(d) % 2) == 1);
    for (int s = 0; s < stp; s++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < CPB; c++) begin
        if (i == 0) exp_q0.push_back(bits[k]);
        else        exp_q1.push_back(bits[k]);
      end
    end
  endtask

  task automatic check_dut(input int i);
    logic exp_tx, exp_rdy, exp_done;
    int sz;
    logic [2:0] st;
    sz = (i == 0) ? exp_q0.size() : exp_q1.size();
    st = (i == 0) ? st0_w : st1_w;
    if (sz == 0) begin
      exp_tx = 1'b1; exp_rdy = 1'b1; exp_done = 1'b0;
    end else begin
      exp_tx   = (i == 0) ? exp_q0[0] : exp_q1[0];
      exp_rdy  = 1'b0;
      exp_done = (sz == 1);
    end
    check_eq($sformatf("tx%0d", i),    32'(tx_w[i]),   32'(exp_tx));
    check_eq($sformatf("ready%0d", i), 32'(rdy_w[i]),  32'(exp_rdy));
    check_eq($sformatf("busy%0d", i),  32'(busy_w[i]), 32'(!exp_rdy));
    check_eq($sformatf("done%0d", i),  32'(done_w[i]), 32'(exp_done));
    check_eq($sformatf("idle_state%0d", i), 32'(st == 3'd0), 32'(exp_rdy));
    if (exp_done) done_exp[i]++;
    if (done_w[i]) done_seen[i]++;
    if (sz > 0) begin
      if (i == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
    m_ready[i] = exp_rdy;
  endtask

  // driver: present inputs for the next edge, model acceptance, check cycle
  task automatic drive(input logic v, input logic [7:0] d);
    VALID   = v;
    DATA_IN = d;
    for (int i = 0; i < 2; i++)
      if (m_ready[i] && v && !RST) push_frame(i, d);
    @(negedge CLK);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      drive(1'b0, 8'($urandom));
      n++;
    end
  endtask

  // Asynchronous reset between clock edges; outputs must go idle at once.
  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_tx%0d", i),    32'(tx_w[i]),   32'd1);
      check_eq($sformatf("rst_ready%0d", i), 32'(rdy_w[i]),  32'd1);
      check_eq($sformatf("rst_busy%0d", i),  32'(busy_w[i]), 32'd0);
      check_eq($sformatf("rst_done%0d", i),  32'(done_w[i]), 32'd0);
    end
    exp_q0.delete();
    exp_q1.delete();
    m_ready = 2'b11;
    repeat (2) drive(1'b0, 8'h00);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; VALID = 1'b0; DATA_IN = 8'h00; m_ready = 2'b11;
    done_exp = '{0, 0}; done_seen = '{0, 0};
    repeat (3) drive(1'b0, 8'h00);
    RST = 1'b0;
    repeat (2) drive(1'b0, 8'h00);

    // reset with no activity
    do_reset();
    repeat (2) drive(1'b0, 8'h00);

    // single frames: basic, parity 1, parity 0
    drive(1'b1, 8'hA5); wait_idle();
    drive(1'b1, 8'h07); wait_idle();
    drive(1'b1, 8'hA5); wait_idle();

    // back-to-back with VALID held high
    drive(1'b1, 8'h00);
    repeat (60) drive(1'b1, 8'hFF);
    wait_idle();

    // inputs toggled during a frame are ignored
    drive(1'b1, 8'h81);
    for (int k = 0; k < 20; k++) drive(1'($urandom_range(0, 1)), 8'h3C);
    wait_idle();
    repeat (3) drive(1'b0, 8'h3C);

    // reset during the data bits, then a clean frame
    drive(1'b1, 8'h55);
    repeat (12) drive(1'b0, 8'h00);
    do_reset();
    repeat (2) drive(1'b0, 8'h00);
    drive(1'b1, 8'hC3); wait_idle();

    // random traffic
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 3) == 0, 8'($urandom));
    wait_idle();
    repeat (2) drive(1'b0, 8'h00);

    check_eq("done_count0", 32'(done_seen[0]), 32'(done_exp[0]));
    check_eq("done_count1", 32'(done_seen[1]), 32'(done_exp[1]));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit path for the serial link. It accepts a parallel byte over a valid/ready handshake and loads it into a parallel-in serial-out shift register. It then frames the byte as start bit, data bits (MSB first), optional even parity bit and stop bit(s), and drives them on the TX line. Bit timing comes from an internal clocks-per-bit counter. The block mirrors the RX serial-in parallel-out shift register, which places the first received bit at the MSB.

Parameters:
SIZE, 8, number of data bits per frame (5..9)
CLKS_PER_BIT, 16, CLK cycles per serial bit (>=2)
PARITY_EN, 0, 1 = append even parity bit after the data bits
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-high
DATA_IN  input  SIZE  byte to transmit; sampled only on handshake
VALID  input  1  DATA_IN is valid
READY  output  1  block can accept a byte (high only in IDLE)
TX  output  1  serial line, idle high, registered
BUSY  output  1  frame in progress (state != IDLE)
DONE  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (async, RST=1): state IDLE, TX=1, READY=1, BUSY=0, DONE=0, bit counter=0, clock counter=0, shift register=0. Outputs take these values immediately, including mid-frame; the frame is aborted and not resumed.
- Handshake: a transfer occurs on a rising edge with VALID=1 and READY=1. DATA_IN is latched into the shift register at that edge. VALID while READY=0 is ignored; no queueing. DATA_IN changes after acceptance do not affect the frame.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE: TX=1, READY=1. On handshake go to START; TX=0 from the acceptance edge.
- Every bit state holds TX constant for exactly CLKS_PER_BIT cycles. The clock counter counts 0..CLKS_PER_BIT-1 and the state/bit advances when the count reaches CLKS_PER_BIT-1.
- DATA: TX = shift register MSB. Shift left by one at each bit boundary. After SIZE bits go to PARITY or STOP.
- PARITY: TX = XOR of all SIZE latched data bits (even parity: total ones including parity bit is even). The parity value is computed at acceptance.
- STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles. DONE=1 on the final cycle, then IDLE on the next edge.
- Frame length: CLKS_PER_BIT*(1+SIZE+PARITY_EN+STOP_BITS) cycles from the acceptance edge to the IDLE entry.
- Back-to-back: READY rises the cycle after DONE. With VALID held high, the next start bit begins one cycle later, so the line idles high for exactly 1 CLK between frames.
- BUSY = !READY. DONE never asserts outside STOP and never on an aborted frame.
- Counter widths: clock counter $clog2(CLKS_PER_BIT), bit counter $clog2(SIZE+1). No wrap occurs beyond the defined terminal counts.

Test Plan:
- Reset values: assert RST mid-simulation with no activity -> TX=1, READY=1, BUSY=0, DONE=0 immediately, without waiting for a CLK edge.
- Basic frame (SIZE=8, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1): send 0xA5 -> TX sequence 0 | 1,0,1,0,0,1,0,1 | 1, each held 4 cycles (40 cycles total); DONE pulses once at cycle 40; READY returns high at cycle 41.
- Parity: PARITY_EN=1, send 0x07 -> parity bit 1. Send 0xA5 -> parity bit 0. Both frames are 44 cycles long.
- Back-to-back with two stop bits (STOP_BITS=2): VALID held high with 0x00 then 0xFF -> second start bit begins exactly 1 cycle after the first DONE. The first frame shows 8 cycles of stop high plus 1 idle cycle. The second frame carries 8 data bits of 1.
- Ignored input: toggle VALID and DATA_IN (0x3C) during a frame of 0x81 -> the transmitted bits equal 0x81, and no extra frame starts after DONE unless VALID is high while READY=1.
- Reset mid-frame: assert RST during the DATA state of 0x55 -> TX=1 at once. After release, READY=1, no DONE pulse, and the next handshake (0xC3) produces a clean full frame.
